pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit that generalises the basic 1-bit reset/increment PC into the CPU's full next-PC stage. Supports configurable width and step, signed relative branches, absolute jumps, call/return through a return-address stack (RAS), stall, and a run/halt state machine. It drives the instruction-memory address and sits between the control unit and the fetch stage.

Parameters:
WIDTH, 8, PC width in bits; all PC arithmetic is modulo 2^WIDTH.
STEP, 1, sequential increment added to PC each advancing cycle.
OFFSET_W, 8, width of the signed branch offset; sign-extended to WIDTH.
RAS_DEPTH, 4, number of return-address stack entries (>=1).

Ports:
CLK  in  1  clock; all state updates on the falling edge, matching the datapath.
RESET  in  1  synchronous, active-high reset.
START  in  1  leave IDLE and begin fetching.
STALL  in  1  hold PC and RAS for this cycle.
HALT  in  1  stop fetching and enter HALTED.
BRANCH  in  1  relative branch request.
OFFSET  in  OFFSET_W  signed two's-complement branch offset.
JUMP  in  1  absolute jump request.
CALL  in  1  call: push the return address, then jump to TARGET.
RET  in  1  return: pop the RAS into PC.
TARGET  in  WIDTH  absolute jump/call destination.
PC  out  WIDTH  current fetch address.
PC_VALID  out  1  PC is a live fetch address (state RUN).
STATE  out  2  IDLE=0, RUN=1, HALTED=2.
RAS_FULL  out  1  RAS holds RAS_DEPTH entries.
RAS_EMPTY  out  1  RAS holds 0 entries.
ERR  out  1  sticky error flag; cleared only by RESET.

Behaviour:
- Reset: one falling edge with RESET=1 gives PC=0, STATE=IDLE, PC_VALID=0, RAS cleared (RAS_EMPTY=1, RAS_FULL=0), ERR=0.
  - RESET overrides every other input in every state, including mid-call or mid-stall.
- IDLE:
  - PC holds 0.
  - START moves to RUN at the next edge with PC=0 and PC_VALID=1. The first fetch address is 0.
  - All other requests are ignored.
- RUN: exactly one action per edge, chosen by this priority:
  - HALT: go to HALTED; PC holds; PC_VALID=0.
  - STALL: PC and RAS hold. Lower-priority requests are dropped, not queued.
  - RET:
    - If the RAS is non-empty, PC <= top entry and the stack pops.
    - If the RAS is empty, PC <= PC+STEP and ERR <= 1.
  - CALL:
    - Push PC+STEP, then PC <= TARGET.
    - If the RAS is full, the push is discarded, ERR <= 1, and the jump still occurs.
  - JUMP: PC <= TARGET.
  - BRANCH: PC <= PC + STEP + sext(OFFSET). Use two's-complement add and truncate to WIDTH.
  - Otherwise: PC <= PC + STEP.
- HALTED:
  - PC holds; PC_VALID=0.
  - START and all other requests are ignored; only RESET exits.
- START while in RUN is ignored.
- RAS is a LIFO with pointer range 0..RAS_DEPTH. RAS_FULL and RAS_EMPTY are registered and reflect the post-edge count.
- Latency: a request sampled at falling edge n is visible on PC immediately after edge n. There is no combinational path from inputs to PC.
- Wrap-around: without the optional feature, 0xFF+1 gives 0x00 for WIDTH=8, silently.

Optional Feature:
Macro PC_WRAP_TRAP_EN.
- Defined: any sequential increment, branch or CALL return-address computation whose unbounded result falls outside 0..2^WIDTH-1 is trapped. On a trap:
  - STATE <= HALTED, PC holds its pre-edge value, ERR <= 1.
  - No RAS change occurs.
- Undefined: all arithmetic wraps modulo 2^WIDTH with no flag.

Test Plan:
1. Reset and start: RESET high for 2 edges, then START pulse, then 3 edges -> IDLE with PC=0, PC_VALID=0; then RUN with PC=0, PC_VALID=1; then PC=1,2,3.
2. Relative branch: at PC=10, BRANCH with OFFSET=8'hFD (-3) -> PC=8; then BRANCH with OFFSET=5 -> PC=14.
3. Priority and stall:
   - At PC=0x20, STALL+JUMP with TARGET=0x40 -> PC stays 0x20.
   - Next cycle, JUMP+BRANCH with OFFSET=4 -> PC=0x40.
   - Next cycle, HALT+CALL -> HALTED, PC=0x40, RAS unchanged.
4. Call/return with RAS_DEPTH=4:
   - At PC=5, CALL with TARGET=0x20 -> PC=0x20, RAS_EMPTY=0; RET -> PC=6.
   - Five nested CALLs -> RAS_FULL=1 after the 4th and ERR=1 after the 5th; four RETs return in LIFO order, then RAS_EMPTY=1.
5. Empty return: RET with RAS empty at PC=0x30 -> PC=0x31, ERR=1. ERR stays 1 through 10 further cycles and clears only on RESET.
6. Wrap at PC=0xFF (WIDTH=8), sequential step:
   - Without the macro -> PC=0x00, STATE=RUN, ERR=0.
   - With PC_WRAP_TRAP_EN -> PC=0xFF, STATE=HALTED, ERR=1; START is ignored; RESET returns to IDLE with PC=0.

Source files
------------

// File: rtl/pc_unit_if.sv
// Bundle of control requests into, and fetch status out of, the program-counter unit.
// Latency: none (wires only).
// Backpressure: none; STALL is an ordinary request carried in this bundle.
// Ports:
//   Requests (control unit -> pc_unit): START STALL HALT BRANCH OFFSET JUMP CALL RET TARGET
//   Status   (pc_unit -> fetch/control): PC PC_VALID STATE RAS_FULL RAS_EMPTY ERR
interface pc_unit_if #(
    parameter int WIDTH    = 8,
    parameter int OFFSET_W = 8
);
    logic                START;
    logic                STALL;
    logic                HALT;
    logic                BRANCH;
    logic [OFFSET_W-1:0] OFFSET;
    logic                JUMP;
    logic                CALL;
    logic                RET;
    logic [WIDTH-1:0]    TARGET;
    logic [WIDTH-1:0]    PC;
    logic                PC_VALID;
    logic [1:0]          STATE;
    logic                RAS_FULL;
    logic                RAS_EMPTY;
    logic                ERR;

    // Control-unit side: drives requests, observes the PC.
    modport master (
        output START, STALL, HALT, BRANCH, OFFSET, JUMP, CALL, RET, TARGET,
        input  PC, PC_VALID, STATE, RAS_FULL, RAS_EMPTY, ERR
    );

    // pc_unit side.
    modport slave (
        input  START, STALL, HALT, BRANCH, OFFSET, JUMP, CALL, RET, TARGET,
        output PC, PC_VALID, STATE, RAS_FULL, RAS_EMPTY, ERR
    );
endinterface

// File: rtl/pc_unit.sv
// Next-PC stage: run/halt FSM, sequential step, relative branch, jump, call/return via a RAS.
// Latency: requests sampled on a falling edge of CLK appear on PC right after that edge; PC is registered.
// Backpressure: STALL holds PC and RAS for one cycle; lower-priority requests that cycle are dropped.
// Ports: CLK, RESET (synchronous, active-high) plus the pc_unit_if.slave bundle.
// Optional: define PC_WRAP_TRAP_EN to halt with ERR when a step, branch or call return
//           address would leave 0..2^WIDTH-1; otherwise arithmetic wraps silently.
module pc_unit #(
    parameter int WIDTH     = 8,
    parameter int STEP      = 1,
    parameter int OFFSET_W  = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic      CLK,
    input  logic      RESET,
    pc_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int SP_W  = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    // Wide enough that PC+STEP+sext(OFFSET) never wraps, so any bit above
    // WIDTH (including a negative sign) flags an out-of-range result.
    localparam int EW    = ((WIDTH > OFFSET_W) ? WIDTH : OFFSET_W) + 2;
    localparam logic [EW-1:0]   STEP_E = EW'(STEP);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(RAS_DEPTH);

`ifdef PC_WRAP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  pc, pc_nxt;
    logic [WIDTH-1:0]  ras [RAS_DEPTH];
    logic [SP_W-1:0]   sp, sp_nxt;
    logic              push;
    logic              err, err_nxt;
    logic              ras_full, ras_empty;

    logic [EW-1:0]     seq_wide, br_wide, off_e;
    logic              seq_trap, br_trap;
    logic [IDX_W-1:0]  top_idx, push_idx;

    assign seq_wide = {{(EW-WIDTH){1'b0}}, pc} + STEP_E;
    assign off_e    = {{(EW-OFFSET_W){bus.OFFSET[OFFSET_W-1]}}, bus.OFFSET};
    assign br_wide  = seq_wide + off_e;
    assign seq_trap = TRAP_EN && (|seq_wide[EW-1:WIDTH]);
    assign br_trap  = TRAP_EN && (|br_wide[EW-1:WIDTH]);

    assign top_idx  = IDX_W'(sp - SP_W'(1));
    assign push_idx = IDX_W'(sp);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        sp_nxt    = sp;
        push      = 1'b0;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                end
            end
            RUN: begin
                if (bus.HALT) begin
                    state_nxt = HALTED;
                end else if (bus.STALL) begin
                    // hold everything
                end else if (bus.RET) begin
                    if (sp != '0) begin
                        pc_nxt = ras[top_idx];
                        sp_nxt = sp - SP_W'(1);
                    end else if (seq_trap) begin
                        state_nxt = HALTED;
                        err_nxt   = 1'b1;
                    end else begin
                        pc_nxt  = seq_wide[WIDTH-1:0];
                        err_nxt = 1'b1;
                    end
                end else if (bus.CALL) begin
                    if (seq_trap) begin
                        state_nxt = HALTED;
                        err_nxt   = 1'b1;
                    end else begin
                        pc_nxt = bus.TARGET;
                        // A full stack drops the return address but the jump still happens.
                        if (sp == SP_FULL) begin
                            err_nxt = 1'b1;
                        end else begin
                            push   = 1'b1;
                            sp_nxt = sp + SP_W'(1);
                        end
                    end
                end else if (bus.JUMP) begin
                    pc_nxt = bus.TARGET;
                end else if (bus.BRANCH) begin
                    if (br_trap) begin
                        state_nxt = HALTED;
                        err_nxt   = 1'b1;
                    end else begin
                        pc_nxt = br_wide[WIDTH-1:0];
                    end
                end else begin
                    if (seq_trap) begin
                        state_nxt = HALTED;
                        err_nxt   = 1'b1;
                    end else begin
                        pc_nxt = seq_wide[WIDTH-1:0];
                    end
                end
            end
            default: begin
                // HALTED: only RESET leaves
            end
        endcase
    end

    always_ff @(negedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            pc        <= '0;
            sp        <= '0;
            err       <= 1'b0;
            ras_full  <= 1'b0;
            ras_empty <= 1'b1;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            sp        <= sp_nxt;
            err       <= err_nxt;
            ras_full  <= (sp_nxt == SP_FULL);
            ras_empty <= (sp_nxt == '0);
        end
    end

    // Stack storage needs no reset: entries above sp are never read.
    always_ff @(negedge CLK) begin
        if (!RESET && push) begin
            ras[push_idx] <= seq_wide[WIDTH-1:0];
        end
    end

    assign bus.PC        = pc;
    assign bus.PC_VALID  = (state == RUN);
    assign bus.STATE     = state;
    assign bus.RAS_FULL  = ras_full;
    assign bus.RAS_EMPTY = ras_empty;
    assign bus.ERR       = err;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed plan steps then random requests, checked against a queue-based model.
// Inputs change 1 time unit after a falling edge; outputs are checked 1 time unit after the next one.
module tb_pc_unit;
    localparam int W  = 8;
    localparam int ST = 1;
    localparam int OW = 8;
    localparam int D  = 4;
    localparam int M  = 1 << W;

`ifdef PC_WRAP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic CLK;
    logic RESET;
    pc_unit_if #(.WIDTH(W), .OFFSET_W(OW)) bus ();

    pc_unit #(.WIDTH(W), .STEP(ST), .OFFSET_W(OW), .RAS_DEPTH(D)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0=IDLE 1=RUN 2=HALTED, PC as an integer, RAS as a queue.
    int m_st  = 0;
    int m_pc  = 0;
    int m_ras[$];
    bit m_err = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Apply one edge of the rules to the model using the inputs now on the bus.
    task automatic model_step();
        int nx;
        if (RESET) begin
            m_st = 0; m_pc = 0; m_err = 1'b0; m_ras.delete();
        end else if (m_st == 0) begin
            if (bus.START) begin m_st = 1; m_pc = 0; end
        end else if (m_st == 1) begin
            if (bus.HALT) begin
                m_st = 2;
            end else if (bus.STALL) begin
            end else if (bus.RET) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin
                    nx = m_pc + ST;
                    m_err = 1'b1;
                    if (TRAP && nx >= M) m_st = 2;
                    else m_pc = nx % M;
                end
            end else if (bus.CALL) begin
                nx = m_pc + ST;
                if (TRAP && nx >= M) begin m_st = 2; m_err = 1'b1; end
                else begin
                    if (m_ras.size() == D) m_err = 1'b1;
                    else m_ras.push_back(nx % M);
                    m_pc = int'(bus.TARGET);
                end
            end else if (bus.JUMP) begin
                m_pc = int'(bus.TARGET);
            end else begin
                nx = m_pc + ST;
                if (bus.BRANCH) nx = nx + int'($signed(bus.OFFSET));
                if (TRAP && (nx < 0 || nx >= M)) begin m_st = 2; m_err = 1'b1; end
                else m_pc = ((nx % M) + M) % M;
            end
        end
    endtask

    task automatic clr();
        RESET = 1'b0;
        bus.START = 1'b0; bus.STALL = 1'b0; bus.HALT = 1'b0; bus.BRANCH = 1'b0;
        bus.JUMP = 1'b0; bus.CALL = 1'b0; bus.RET = 1'b0;
        bus.OFFSET = '0; bus.TARGET = '0;
    endtask

    task automatic tick(input string tag);
        model_step();
        @(negedge CLK);
        #1;
        chk({tag, ":pc"},    int'(bus.PC),        m_pc);
        chk({tag, ":valid"}, int'(bus.PC_VALID),  int'(m_st == 1));
        chk({tag, ":state"}, int'(bus.STATE),     m_st);
        chk({tag, ":full"},  int'(bus.RAS_FULL),  int'(m_ras.size() == D));
        chk({tag, ":empty"}, int'(bus.RAS_EMPTY), int'(m_ras.size() == 0));
        chk({tag, ":err"},   int'(bus.ERR),       int'(m_err));
        clr();
    endtask

    task automatic restart();
        RESET = 1'b1; tick("rst");
        bus.START = 1'b1; tick("start");
    endtask

    task automatic jump_to(input int t);
        bus.JUMP = 1'b1; bus.TARGET = W'(t); tick("jmp");
    endtask

    initial begin
        clr();
        // 1. reset and start
        RESET = 1'b1; tick("p1_rst0");
        RESET = 1'b1; tick("p1_rst1");
        chk("p1_idle_pc", int'(bus.PC), 0);
        bus.START = 1'b1; tick("p1_start");
        chk("p1_run_valid", int'(bus.PC_VALID), 1);
        tick("p1_s1"); tick("p1_s2"); tick("p1_s3");
        chk("p1_pc3", int'(bus.PC), 3);
        bus.START = 1'b1; tick("p1_start_in_run");

        // 2. relative branch
        jump_to(10);
        bus.BRANCH = 1'b1; bus.OFFSET = 8'hFD; tick("p2_back");
        chk("p2_pc8", int'(bus.PC), 8);
        bus.BRANCH = 1'b1; bus.OFFSET = 8'd5; tick("p2_fwd");
        chk("p2_pc14", int'(bus.PC), 14);

        // 3. priority and stall
        jump_to(32'h20);
        bus.STALL = 1'b1; bus.JUMP = 1'b1; bus.TARGET = 8'h40; tick("p3_stall");
        chk("p3_hold", int'(bus.PC), 32'h20);
        bus.JUMP = 1'b1; bus.BRANCH = 1'b1; bus.TARGET = 8'h40; bus.OFFSET = 8'd4; tick("p3_jmp");
        bus.HALT = 1'b1; bus.CALL = 1'b1; bus.TARGET = 8'h77; tick("p3_halt");
        chk("p3_halted", int'(bus.STATE), 2);
        bus.START = 1'b1; tick("p3_start_ignored");

        // 4. call/return, nesting to overflow
        restart();
        jump_to(5);
        bus.CALL = 1'b1; bus.TARGET = 8'h20; tick("p4_call");
        bus.RET = 1'b1; tick("p4_ret");
        chk("p4_ret_pc", int'(bus.PC), 6);
        for (int i = 1; i <= 5; i++) begin
            bus.CALL = 1'b1; bus.TARGET = W'(i * 16); tick($sformatf("p4_call%0d", i));
        end
        chk("p4_err_after5", int'(bus.ERR), 1);
        for (int i = 1; i <= 4; i++) begin
            bus.RET = 1'b1; tick($sformatf("p4_ret%0d", i));
        end
        chk("p4_lifo_last", int'(bus.PC), 7);

        // 5. empty return, sticky error
        restart();
        jump_to(32'h30);
        bus.RET = 1'b1; tick("p5_ret_empty");
        chk("p5_pc31", int'(bus.PC), 32'h31);
        for (int i = 0; i < 10; i++) tick("p5_sticky");
        RESET = 1'b1; tick("p5_clear");

        // 6. wrap at top of address space
        bus.START = 1'b1; tick("p6_start");
        jump_to(32'hFF);
        tick("p6_wrap");
        bus.START = 1'b1; tick("p6_after");
        RESET = 1'b1; tick("p6_reset");

        // Random requests
        restart();
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            RESET      = (m_st == 2) ? (r < 30) : (r < 2);
            bus.START  = ($urandom_range(0, 9) == 0);
            bus.HALT   = ($urandom_range(0, 39) == 0);
            bus.STALL  = ($urandom_range(0, 6) == 0);
            bus.RET    = ($urandom_range(0, 5) == 0);
            bus.CALL   = ($urandom_range(0, 5) == 0);
            bus.JUMP   = ($urandom_range(0, 9) == 0);
            bus.BRANCH = ($urandom_range(0, 4) == 0);
            bus.OFFSET = OW'($urandom);
            bus.TARGET = W'($urandom);
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
